// File: rtl/regfile_write_arbiter_pkg.sv
// Shared widths and types for the register file write-back path.
package regfile_write_arbiter_pkg;

   localparam int WORD_WIDTH           = 32;
   localparam int REGISTER_INDEX_WIDTH = 5;
   localparam int NUM_REGS             = 32;

   typedef logic [WORD_WIDTH-1:0]           word_t;
   typedef logic [REGISTER_INDEX_WIDTH-1:0] reg_idx_t;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Write-back request bus: requester i occupies slice i of the packed idx/data vectors.
interface regfile_write_arbiter_if #(parameter int NUM_REQ = 3);
   import regfile_write_arbiter_pkg::*;

   logic [NUM_REQ-1:0]                      req_valid;
   logic [NUM_REQ*REGISTER_INDEX_WIDTH-1:0] req_idx;
   logic [NUM_REQ*WORD_WIDTH-1:0]           req_data;
   logic [NUM_REQ-1:0]                      req_ready;

   modport master (output req_valid, req_idx, req_data, input req_ready);
   modport slave  (input req_valid, req_idx, req_data, output req_ready);

endinterface

// File: rtl/regfile_write_arbiter_rr_arb.sv
// Combinational round-robin pick: first valid requester at or after ptr_i, one-hot plus encoded.
module round_robin_arbiter #(
   parameter int NUM_REQ = 3,
   parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] valid_i,
   input  logic [PTR_W-1:0]   ptr_i,
   output logic [NUM_REQ-1:0] grant_o,
   output logic [PTR_W-1:0]   grant_idx_o,
   output logic               grant_vld_o
);

   int cand;

   always_comb begin
      grant_o     = '0;
      grant_idx_o = '0;
      grant_vld_o = 1'b0;
      cand        = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = (int'(ptr_i) + k) % NUM_REQ;
         if (!grant_vld_o && valid_i[cand]) begin
            grant_vld_o       = 1'b1;
            grant_o[cand]     = 1'b1;
            grant_idx_o       = PTR_W'(cand);
         end
      end
   end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin share of the register file write port plus RAW pending-write scoreboard.
// Grant to rf_write_* is one cycle; one requester is accepted per cycle, the rest see ready low.
module regfile_write_arbiter
   import regfile_write_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 3
) (
   input  logic                   clk,
   input  logic                   reset,
   regfile_write_arbiter_if.slave req,
   input  logic                   issue_valid,
   input  reg_idx_t               issue_idx,
   input  reg_idx_t               rs1_idx,
   input  reg_idx_t               rs2_idx,
   output logic                   rs1_busy,
   output logic                   rs2_busy,
   output logic                   rf_write_enable,
   output reg_idx_t               rf_write_idx,
   output word_t                  rf_write_data,
   output logic [NUM_REGS-1:0]    pending
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [PTR_W-1:0]    ptr_q, ptr_d;
   logic [NUM_REQ-1:0]  grant;
   logic [PTR_W-1:0]    grant_idx;
   logic                grant_vld;
   logic                hs;
   reg_idx_t            win_idx;
   word_t               win_data;
   logic                we_q, we_d;
   reg_idx_t            widx_q, widx_d;
   word_t               wdata_q, wdata_d;
   logic [NUM_REGS-1:0] pending_q, pending_d;

   round_robin_arbiter #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_arb (
      .valid_i     (req.req_valid),
      .ptr_i       (ptr_q),
      .grant_o     (grant),
      .grant_idx_o (grant_idx),
      .grant_vld_o (grant_vld)
   );

   assign req.req_ready = reset ? '0 : grant;
   assign hs            = grant_vld && !reset;
   assign win_idx       = req.req_idx[int'(grant_idx)*REGISTER_INDEX_WIDTH +: REGISTER_INDEX_WIDTH];
   assign win_data      = req.req_data[int'(grant_idx)*WORD_WIDTH +: WORD_WIDTH];

   always_comb begin
      ptr_d   = ptr_q;
      we_d    = 1'b0;
      widx_d  = widx_q;
      wdata_d = wdata_q;
      if (hs) begin
         ptr_d   = (grant_idx == PTR_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
         we_d    = (win_idx != '0);
         widx_d  = win_idx;
         wdata_d = win_data;
      end
   end

   // Clear first, then set, so a newly issued producer of the same register wins.
   always_comb begin
      pending_d = pending_q;
      if (we_q)
         pending_d[widx_q] = 1'b0;
      if (issue_valid && issue_idx != '0)
         pending_d[issue_idx] = 1'b1;
      pending_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_q     <= '0;
         we_q      <= 1'b0;
         widx_q    <= '0;
         wdata_q   <= '0;
         pending_q <= '0;
      end else begin
         ptr_q     <= ptr_d;
         we_q      <= we_d;
         widx_q    <= widx_d;
         wdata_q   <= wdata_d;
         pending_q <= pending_d;
      end
   end

   assign rf_write_enable = we_q;
   assign rf_write_idx    = widx_q;
   assign rf_write_data   = wdata_q;
   assign pending         = pending_q;
   assign rs1_busy        = pending_q[rs1_idx];
   assign rs2_busy        = pending_q[rs2_idx];

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: expected writes queued at grant, popped at the write port.
module tb_regfile_write_arbiter;
   import regfile_write_arbiter_pkg::*;

   logic        clk;
   logic        reset;
   logic        issue_valid;
   logic [4:0]  issue_idx, rs1_idx, rs2_idx;
   logic        rs1_busy, rs2_busy;
   logic        rf_write_enable;
   logic [4:0]  rf_write_idx;
   logic [31:0] rf_write_data;
   logic [31:0] pending;

   regfile_write_arbiter_if #(.NUM_REQ(3)) bus ();

   regfile_write_arbiter #(.NUM_REQ(3)) dut (
      .clk             (clk),
      .reset           (reset),
      .req             (bus),
      .issue_valid     (issue_valid),
      .issue_idx       (issue_idx),
      .rs1_idx         (rs1_idx),
      .rs2_idx         (rs2_idx),
      .rs1_busy        (rs1_busy),
      .rs2_busy        (rs2_busy),
      .rf_write_enable (rf_write_enable),
      .rf_write_idx    (rf_write_idx),
      .rf_write_data   (rf_write_data),
      .pending         (pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Downstream register file fed by the write port.
   logic [31:0] tb_rf [32];
   always @(posedge clk)
      if (rf_write_enable) tb_rf[rf_write_idx] <= rf_write_data;

   typedef struct {
      logic        we;
      logic [4:0]  idx;
      logic [31:0] data;
   } wr_t;

   wr_t         exp_q[$];
   int          n_cmp  = 0;
   int          n_fail = 0;
   int          m_ptr  = 0;
   logic [31:0] m_pending = '0;
   logic        m_we   = 1'b0;
   logic [4:0]  m_idx  = '0;

   function automatic int model_winner(logic [2:0] v, int p);
      for (int k = 0; k < 3; k++)
         if (v[(p + k) % 3]) return (p + k) % 3;
      return -1;
   endfunction

   task automatic set_req(int i, logic v, logic [4:0] ix, logic [31:0] d);
      bus.req_valid[i]        = v;
      bus.req_idx[i*5 +: 5]   = ix;
      bus.req_data[i*32 +: 32] = d;
   endtask

   // Update the reference model for the coming edge, then step one clock.
   task automatic advance(output int g);
      wr_t e;
      g = model_winner(bus.req_valid, m_ptr);
      if (reset) begin
         g = -1;
         m_ptr = 0; m_pending = '0; m_we = 1'b0;
         exp_q.delete();
      end else begin
         if (m_we) m_pending[m_idx] = 1'b0;
         if (issue_valid && issue_idx != 0) m_pending[issue_idx] = 1'b1;
         m_we = 1'b0;
         if (g >= 0) begin
            e.idx  = bus.req_idx[g*5 +: 5];
            e.data = bus.req_data[g*32 +: 32];
            e.we   = (e.idx != 0);
            exp_q.push_back(e);
            m_ptr = (g + 1) % 3;
            m_we  = e.we;
            m_idx = e.idx;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      int g;
      reset = 1'b1;
      for (int i = 0; i < 3; i++) set_req(i, 1'b1, 5'(i + 1), 32'hA000_0000 + i);
      issue_valid = 1'b1; issue_idx = 5'd3;
      for (int c = 0; c < 2; c++) begin
         advance(g);
         n_cmp++;
         if (bus.req_ready !== 3'b000) begin n_fail++; $display("FAIL reset_ready cyc%0d got %b want 000", c, bus.req_ready); end
         n_cmp++;
         if (rf_write_enable !== 1'b0) begin n_fail++; $display("FAIL reset_we cyc%0d got %b want 0", c, rf_write_enable); end
         n_cmp++;
         if (pending !== 32'h0) begin n_fail++; $display("FAIL reset_pending cyc%0d got %h want 0", c, pending); end
      end
      reset = 1'b0; issue_valid = 1'b0;
      #1;
      n_cmp++;
      if (bus.req_ready !== 3'b001) begin n_fail++; $display("FAIL reset_first_grant got %b want 001", bus.req_ready); end
   endtask

   task automatic test_contention();
      int  g;
      int  seq [6] = '{0, 1, 2, 0, 1, 2};
      wr_t e;
      for (int k = 0; k < 6; k++) begin
         n_cmp++;
         if (bus.req_ready !== 3'(1 << seq[k])) begin n_fail++; $display("FAIL contention_grant k%0d got %b want req%0d", k, bus.req_ready, seq[k]); end
         advance(g);
         if (exp_q.size() == 0) begin
            n_cmp++; n_fail++; $display("FAIL contention_queue k%0d got empty want entry", k);
         end else begin
            e = exp_q.pop_front();
            n_cmp++;
            if ({rf_write_enable, rf_write_idx, rf_write_data} !== {e.we, e.idx, e.data}) begin
               n_fail++;
               $display("FAIL contention_write k%0d got we%b r%0d %h want we%b r%0d %h", k,
                        rf_write_enable, rf_write_idx, rf_write_data, e.we, e.idx, e.data);
            end
         end
         if (g >= 0) set_req(g, 1'b1, 5'(11 + k), $urandom);
      end
      for (int i = 0; i < 3; i++) set_req(i, 1'b0, 5'd0, 32'h0);
      advance(g);
      n_cmp++;
      if (rf_write_enable !== 1'b0) begin n_fail++; $display("FAIL contention_idle_we got %b want 0", rf_write_enable); end
   endtask

   task automatic test_raw_clear();
      int  g;
      wr_t e;
      issue_valid = 1'b1; issue_idx = 5'd5; rs1_idx = 5'd5; rs2_idx = 5'd6;
      advance(g);
      issue_valid = 1'b0;
      n_cmp++;
      if ({rs1_busy, rs2_busy} !== 2'b10) begin n_fail++; $display("FAIL raw_busy_after_issue got %b%b want 10", rs1_busy, rs2_busy); end
      set_req(1, 1'b1, 5'd5, 32'hDEAD_BEEF);
      #1;
      n_cmp++;
      if (bus.req_ready !== 3'b010) begin n_fail++; $display("FAIL raw_grant got %b want 010", bus.req_ready); end
      advance(g);
      set_req(1, 1'b0, 5'd0, 32'h0);
      e = exp_q.pop_front();
      n_cmp++;
      if ({rf_write_enable, rf_write_idx, rf_write_data} !== {e.we, e.idx, e.data}) begin
         n_fail++;
         $display("FAIL raw_write got we%b r%0d %h want we%b r%0d %h",
                  rf_write_enable, rf_write_idx, rf_write_data, e.we, e.idx, e.data);
      end
      n_cmp++;
      if (rs1_busy !== 1'b1) begin n_fail++; $display("FAIL raw_busy_n1 got %b want 1", rs1_busy); end
      advance(g);
      n_cmp++;
      if (rs1_busy !== 1'b0) begin n_fail++; $display("FAIL raw_busy_n2 got %b want 0", rs1_busy); end
      n_cmp++;
      if (tb_rf[5] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL raw_rf_value got %h want deadbeef", tb_rf[5]); end
      n_cmp++;
      if (pending !== m_pending) begin n_fail++; $display("FAIL raw_pending got %h want %h", pending, m_pending); end
   endtask

   task automatic test_r0();
      int  g;
      wr_t e;
      issue_valid = 1'b1; issue_idx = 5'd0;
      advance(g);
      issue_valid = 1'b0;
      n_cmp++;
      if (pending !== 32'h0) begin n_fail++; $display("FAIL r0_issue_pending got %h want 0", pending); end
      set_req(2, 1'b1, 5'd0, 32'hFFFF_FFFF);
      #1;
      n_cmp++;
      if (bus.req_ready !== 3'b100) begin n_fail++; $display("FAIL r0_grant got %b want 100", bus.req_ready); end
      advance(g);
      set_req(2, 1'b0, 5'd0, 32'h0);
      e = exp_q.pop_front();
      n_cmp++;
      if (rf_write_enable !== 1'b0 || rf_write_enable !== e.we) begin
         n_fail++; $display("FAIL r0_write_dropped got we%b want 0", rf_write_enable);
      end
      n_cmp++;
      if (pending[0] !== 1'b0) begin n_fail++; $display("FAIL r0_pending0 got %b want 0", pending[0]); end
   endtask

   task automatic test_set_wins();
      int  g;
      wr_t e;
      issue_valid = 1'b1; issue_idx = 5'd7;
      advance(g);
      issue_valid = 1'b0;
      n_cmp++;
      if (pending[7] !== 1'b1) begin n_fail++; $display("FAIL setwins_issue got %b want 1", pending[7]); end
      set_req(0, 1'b1, 5'd7, 32'h1234_5678);
      advance(g);
      set_req(0, 1'b0, 5'd0, 32'h0);
      e = exp_q.pop_front();
      n_cmp++;
      if ({rf_write_enable, rf_write_idx, rf_write_data} !== {e.we, e.idx, e.data}) begin
         n_fail++;
         $display("FAIL setwins_write got we%b r%0d %h want we%b r%0d %h",
                  rf_write_enable, rf_write_idx, rf_write_data, e.we, e.idx, e.data);
      end
      issue_valid = 1'b1; issue_idx = 5'd7;
      advance(g);
      issue_valid = 1'b0;
      n_cmp++;
      if (pending[7] !== 1'b1) begin n_fail++; $display("FAIL setwins_collision got %b want 1", pending[7]); end
      advance(g);
      n_cmp++;
      if (pending !== m_pending) begin n_fail++; $display("FAIL setwins_hold got %h want %h", pending, m_pending); end
   endtask

   task automatic test_reset_midstream();
      int  g;
      wr_t e;
      issue_valid = 1'b1; issue_idx = 5'd9;
      advance(g);
      issue_idx = 5'd10;
      advance(g);
      issue_valid = 1'b0;
      set_req(1, 1'b1, 5'd9, 32'hCAFE_F00D);
      advance(g);
      set_req(1, 1'b0, 5'd0, 32'h0);
      e = exp_q.pop_front();
      n_cmp++;
      if ({rf_write_enable, rf_write_idx, rf_write_data} !== {e.we, e.idx, e.data}) begin
         n_fail++;
         $display("FAIL midrst_write got we%b r%0d %h want we%b r%0d %h",
                  rf_write_enable, rf_write_idx, rf_write_data, e.we, e.idx, e.data);
      end
      reset = 1'b1;
      set_req(0, 1'b1, 5'd4, 32'h5555_AAAA);
      issue_valid = 1'b1; issue_idx = 5'd12;
      advance(g);
      n_cmp++;
      if (rf_write_enable !== 1'b0) begin n_fail++; $display("FAIL midrst_we got %b want 0", rf_write_enable); end
      n_cmp++;
      if (pending !== 32'h0) begin n_fail++; $display("FAIL midrst_pending got %h want 0", pending); end
      n_cmp++;
      if (bus.req_ready !== 3'b000) begin n_fail++; $display("FAIL midrst_ready got %b want 000", bus.req_ready); end
      reset = 1'b0; issue_valid = 1'b0;
      set_req(0, 1'b0, 5'd0, 32'h0);
      advance(g);
      n_cmp++;
      if ({rf_write_enable, pending} !== {1'b0, m_pending}) begin
         n_fail++; $display("FAIL midrst_after got we%b %h want we0 %h", rf_write_enable, pending, m_pending);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; issue_valid = 1'b0; issue_idx = '0; rs1_idx = '0; rs2_idx = '0;
      bus.req_valid = '0; bus.req_idx = '0; bus.req_data = '0;
      test_reset();
      test_contention();
      test_raw_clear();
      test_r0();
      test_set_wins();
      test_reset_midstream();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
